life_frame_scheduler: RTL and testbench

//   Sequences the Game of Life datapath against the VGA raster. Consumes h_count/v_count from
//   the horizontal/vertical counters and generates registered hsync/vsync/video_on. Grants

---
 rtl/life_frame_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_life_frame_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_frame_scheduler.sv
// life_frame_scheduler
//   Sequences the Game of Life generation engine against the VGA raster. It produces
//   registered hsync/vsync/video_on from the incoming h_count/v_count. It grants the engine
//   frame-buffer access only during vertical blanking. It swaps display and update buffers at
//   the top of a frame, so the visible picture never tears.
//
// Ports
//   clk        in   pixel clock
//   rst_n      in   asynchronous active-low reset
//   h_count    in   [15:0] horizontal raster position
//   v_count    in   [15:0] vertical raster position
//   run        in   level, free-running generations every FRAMES_PER_GEN frames
//   step_req   in   one-cycle pulse, request exactly one generation
//   gen_done   in   one-cycle pulse from the engine, generation fully written
//   hsync      out  horizontal sync, active low
//   vsync      out  vertical sync, active low
//   video_on   out  high inside the visible area
//   gen_start  out  one-cycle pulse, engine begins a generation
//   upd_grant  out  engine may access the frame buffer while high
//   buf_sel    out  buffer being displayed; the engine writes ~buf_sel
//   gen_busy   out  high from gen_start until the buffer swap
module life_frame_scheduler #(
   parameter int unsigned H_ACTIVE       = 640,
   parameter int unsigned H_FP           = 16,
   parameter int unsigned H_SYNC         = 96,
   parameter int unsigned V_ACTIVE       = 480,
   parameter int unsigned V_FP           = 10,
   parameter int unsigned V_SYNC         = 2,
   parameter int unsigned FRAMES_PER_GEN = 30
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] h_count,
   input  logic [15:0] v_count,
   input  logic        run,
   input  logic        step_req,
   input  logic        gen_done,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic        gen_start,
   output logic        upd_grant,
   output logic        buf_sel,
   output logic        gen_busy
);

   localparam logic [15:0] HActive   = 16'(H_ACTIVE);
   localparam logic [15:0] VActive   = 16'(V_ACTIVE);
   localparam logic [15:0] HsBegin   = 16'(H_ACTIVE + H_FP);
   localparam logic [15:0] HsEnd     = 16'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [15:0] VsBegin   = 16'(V_ACTIVE + V_FP);
   localparam logic [15:0] VsEnd     = 16'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [7:0]  FrameLast = 8'(FRAMES_PER_GEN - 1);

   typedef enum logic [1:0] {StIdle, StUpdate, StPause, StSwap} state_e;

   state_e     state_q, state_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic       hsync_q, vsync_q, video_on_q;
   logic       gen_start_q, gen_start_d;
   logic       upd_grant_q, upd_grant_d;
   logic       buf_sel_q, buf_sel_d;
   logic       gen_busy_q, gen_busy_d;
   logic       swap_pend_q, swap_pend_d;
   logic       armed_q, armed_d;

   logic frame_tick, at_origin, in_vblank, cnt_wrap, arm_req, start_gen;

   // Start of vertical blanking and top-left of the frame.
   assign frame_tick = (h_count == 16'd0) && (v_count == VActive);
   assign at_origin  = (h_count == 16'd0) && (v_count == 16'd0);
   assign in_vblank  = (v_count >= VActive);

   // Generation pacing in run mode. The counter holds while run is low.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      cnt_wrap    = 1'b0;
      if (frame_tick && run) begin
         if (frame_cnt_q >= FrameLast) begin
            frame_cnt_d = 8'd0;
            cnt_wrap    = 1'b1;
         end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
         end
      end
   end

   // A request raised on the same tick that launches a generation is absorbed by it.
   assign arm_req   = step_req | cnt_wrap;
   assign start_gen = (state_q == StIdle) && frame_tick && (armed_q || arm_req);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start_gen) state_d = StUpdate;
         end
         StUpdate: begin
            // gen_done beats the end of blanking.
            if (gen_done)        state_d = at_origin ? StIdle : StSwap;
            else if (!in_vblank) state_d = StPause;
         end
         StPause: begin
            if (gen_done)        state_d = at_origin ? StIdle : StSwap;
            else if (frame_tick) state_d = StUpdate;
         end
         StSwap: begin
            if (at_origin) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs. These are next values of registered outputs.
   always_comb begin
      gen_start_d = 1'b0;
      upd_grant_d = 1'b0;
      buf_sel_d   = buf_sel_q;
      gen_busy_d  = gen_busy_q;
      swap_pend_d = swap_pend_q;
      armed_d     = armed_q | arm_req;
      unique case (state_q)
         StIdle: begin
            if (start_gen) begin
               gen_start_d = 1'b1;
               upd_grant_d = 1'b1;
               gen_busy_d  = 1'b1;
               armed_d     = 1'b0;
            end
         end
         StUpdate, StPause: begin
            if (gen_done) begin
               if (at_origin) begin
                  // Completion lands exactly on the frame boundary, so swap now.
                  buf_sel_d   = ~buf_sel_q;
                  gen_busy_d  = 1'b0;
                  swap_pend_d = 1'b0;
               end else begin
                  swap_pend_d = 1'b1;
               end
            end else if (state_q == StUpdate) begin
               upd_grant_d = in_vblank;
            end else begin
               upd_grant_d = frame_tick;
            end
         end
         StSwap: begin
            if (at_origin && swap_pend_q) begin
               buf_sel_d   = ~buf_sel_q;
               gen_busy_d  = 1'b0;
               swap_pend_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync_q     <= 1'b1;
         vsync_q     <= 1'b1;
         video_on_q  <= 1'b0;
         gen_start_q <= 1'b0;
         upd_grant_q <= 1'b0;
         buf_sel_q   <= 1'b0;
         gen_busy_q  <= 1'b0;
         swap_pend_q <= 1'b0;
         armed_q     <= 1'b0;
         frame_cnt_q <= 8'd0;
      end else begin
         hsync_q     <= !((h_count >= HsBegin) && (h_count < HsEnd));
         vsync_q     <= !((v_count >= VsBegin) && (v_count < VsEnd));
         video_on_q  <= (h_count < HActive) && (v_count < VActive);
         gen_start_q <= gen_start_d;
         upd_grant_q <= upd_grant_d;
         buf_sel_q   <= buf_sel_d;
         gen_busy_q  <= gen_busy_d;
         swap_pend_q <= swap_pend_d;
         armed_q     <= armed_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign hsync     = hsync_q;
   assign vsync     = vsync_q;
   assign video_on  = video_on_q;
   assign gen_start = gen_start_q;
   assign upd_grant = upd_grant_q;
   assign buf_sel   = buf_sel_q;
   assign gen_busy  = gen_busy_q;

endmodule

// File: tb/tb_life_frame_scheduler.sv
// Bench for life_frame_scheduler. It uses the full 800-pixel line timing and a shortened
// 7-line frame: 4 active lines, FP 1, sync 1, BP 1. It also sets FRAMES_PER_GEN = 2.
module tb_life_frame_scheduler;

   localparam int HTot = 800;
   localparam int HAct = 640;
   localparam int HsB  = 656;
   localparam int HsE  = 752;
   localparam int VAct = 4;
   localparam int VsB  = 5;
   localparam int VsE  = 6;
   localparam int VTot = 7;

   localparam int EvStart = 0;
   localparam int EvSwap  = 1;

   logic        clk, rst_n, run, step_req, gen_done;
   logic [15:0] h_count, v_count;
   logic        hsync, vsync, video_on, gen_start, upd_grant, buf_sel, gen_busy;

   int frame_no;
   int n_vec = 0;
   int n_bad = 0;
   int eng_delay = 100;

   typedef struct {
      int   kind;
      int   f;
      int   v;
      int   h;
      logic b;
   } ev_t;
   ev_t sbq[$];

   life_frame_scheduler #(
      .V_ACTIVE       (4),
      .V_FP           (1),
      .V_SYNC         (1),
      .FRAMES_PER_GEN (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .h_count   (h_count),
      .v_count   (v_count),
      .run       (run),
      .step_req  (step_req),
      .gen_done  (gen_done),
      .hsync     (hsync),
      .vsync     (vsync),
      .video_on  (video_on),
      .gen_start (gen_start),
      .upd_grant (upd_grant),
      .buf_sel   (buf_sel),
      .gen_busy  (gen_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Raster counters advance on the falling edge.
   initial begin
      h_count  = 16'd0;
      v_count  = 16'd0;
      frame_no = 0;
      forever begin
         @(negedge clk);
         if (int'(h_count) == HTot - 1) begin
            h_count = 16'd0;
            if (int'(v_count) == VTot - 1) begin
               v_count  = 16'd0;
               frame_no = frame_no + 1;
            end else begin
               v_count = v_count + 16'd1;
            end
         end else begin
            h_count = h_count + 16'd1;
         end
      end
   end

   // Engine model: gen_done arrives eng_delay pixels after gen_start.
   initial begin
      gen_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (rst_n && gen_start) begin
            repeat (eng_delay) @(negedge clk);
            #1 gen_done = 1'b1;
            @(negedge clk); #1 gen_done = 1'b0;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (frame %0d v=%0d h=%0d)", name, act, exp,
                  frame_no, v_count, h_count);
      end
   endtask

   task automatic sb_push(input int kind, input int f, input int v, input int h, input logic b);
      ev_t e;
      e.kind = kind;
      e.f = f;
      e.v = v;
      e.h = h;
      e.b = b;
      sbq.push_back(e);
   endtask

   task automatic sb_pop(input int kind, input logic b);
      ev_t e;
      n_vec++;
      if (sbq.size() == 0) begin
         n_bad++;
         $display("FAIL sb_event: got kind=%0d at frame %0d v=%0d h=%0d, required no event",
                  kind, frame_no, v_count, h_count);
      end else begin
         e = sbq.pop_front();
         if (e.kind != kind || e.f != frame_no || e.v != int'(v_count) ||
             e.h != int'(h_count) || (kind == EvSwap && e.b !== b)) begin
            n_bad++;
            $display("FAIL sb_event: got kind=%0d f=%0d v=%0d h=%0d buf=%0d, required kind=%0d f=%0d v=%0d h=%0d buf=%0d",
                     kind, frame_no, v_count, h_count, b, e.kind, e.f, e.v, e.h, e.b);
         end
      end
   endtask

   task automatic at_pos(input int f, input int v, input int h);
      bit found = 1'b0;
      for (int n = 0; n < 20000 && !found; n++) begin
         @(negedge clk); #1;
         found = (frame_no == f) && (int'(v_count) == v) && (int'(h_count) == h);
      end
      if (!found) begin
         n_vec++;
         n_bad++;
         $display("FAIL at_pos timeout: got frame %0d v=%0d h=%0d, required frame %0d v=%0d h=%0d",
                  frame_no, v_count, h_count, f, v, h);
      end
   endtask

   task automatic sample();
      @(posedge clk); #1;
   endtask

   task automatic pulse_step();
      step_req = 1'b1;
      @(negedge clk); #1;
      step_req = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_hsync"}, int'(hsync), 1);
      check({tag, "_vsync"}, int'(vsync), 1);
      check({tag, "_video_on"}, int'(video_on), 0);
      check({tag, "_gen_start"}, int'(gen_start), 0);
      check({tag, "_upd_grant"}, int'(upd_grant), 0);
      check({tag, "_buf_sel"}, int'(buf_sel), 0);
      check({tag, "_gen_busy"}, int'(gen_busy), 0);
   endtask

   // Monitor: pops the scoreboard on each gen_start and buf_sel change, and audits every line.
   initial begin
      int   bad_sync = 0, hs_low = 0, hs_first = -1, overlap = 0, wide = 0;
      bit   line_dirty = 1'b1;
      logic prev_buf = 1'b0, prev_start = 1'b0;
      logic exp_hs, exp_vs, exp_vo;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            line_dirty = 1'b1;
            prev_buf   = 1'b0;
            prev_start = 1'b0;
         end else begin
            if (gen_start) sb_pop(EvStart, 1'b0);
            if (buf_sel !== prev_buf) sb_pop(EvSwap, buf_sel);
            prev_buf = buf_sel;
            exp_hs = !(int'(h_count) >= HsB && int'(h_count) < HsE);
            exp_vs = !(int'(v_count) >= VsB && int'(v_count) < VsE);
            exp_vo = (int'(h_count) < HAct) && (int'(v_count) < VAct);
            if (hsync !== exp_hs || vsync !== exp_vs || video_on !== exp_vo) bad_sync++;
            if (upd_grant && video_on) overlap++;
            if (gen_start && prev_start) wide++;
            prev_start = gen_start;
            if (!hsync) begin
               hs_low++;
               if (hs_first < 0) hs_first = int'(h_count);
            end
         end
         if (int'(h_count) == HTot - 1) begin
            if (!line_dirty) begin
               check("sync_line", bad_sync, 0);
               check("hsync_width", hs_low, HsE - HsB);
               check("hsync_start", hs_first, HsB);
               check("grant_during_video", overlap, 0);
               check("gen_start_width", wide, 0);
            end
            bad_sync   = 0;
            hs_low     = 0;
            hs_first   = -1;
            overlap    = 0;
            wide       = 0;
            line_dirty = 1'b0;
         end
      end
   end

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: got no end of run, required end within 90000 cycles");
      $fatal(1);
   end

   initial begin
      rst_n    = 1'b0;
      run      = 1'b0;
      step_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      @(negedge clk); #1;
      rst_n = 1'b1;

      // Single step with run low.
      at_pos(0, 1, 100);
      pulse_step();
      sb_push(EvStart, 0, 4, 0, 1'b0);
      sb_push(EvSwap, 1, 0, 0, 1'b1);
      at_pos(0, 4, 50);
      sample();
      check("busy_in_gen", int'(gen_busy), 1);
      check("grant_in_vblank", int'(upd_grant), 1);
      at_pos(1, 0, 10);
      sample();
      check("busy_after_swap", int'(gen_busy), 0);

      // gen_done withheld until the next vblank.
      at_pos(1, 1, 100);
      eng_delay = 6400;
      pulse_step();
      sb_push(EvStart, 1, 4, 0, 1'b0);
      sb_push(EvSwap, 3, 0, 0, 1'b0);
      at_pos(1, 5, 0);
      sample();
      check("grant_vblank", int'(upd_grant), 1);
      at_pos(2, 0, 0);
      sample();
      check("grant_drop_at_v0", int'(upd_grant), 0);
      at_pos(2, 2, 300);
      sample();
      check("grant_paused", int'(upd_grant), 0);
      check("busy_paused", int'(gen_busy), 1);
      at_pos(2, 4, 0);
      sample();
      check("grant_resume", int'(upd_grant), 1);
      at_pos(2, 5, 10);
      sample();
      check("grant_after_done", int'(upd_grant), 0);

      // step_req while busy is served on the vblank after the swap.
      eng_delay = 100;
      at_pos(3, 1, 100);
      pulse_step();
      sb_push(EvStart, 3, 4, 0, 1'b0);
      sb_push(EvSwap, 4, 0, 0, 1'b1);
      at_pos(3, 5, 0);
      pulse_step();
      sb_push(EvStart, 4, 4, 0, 1'b0);
      sb_push(EvSwap, 5, 0, 0, 1'b0);
      sample();
      check("busy_at_queued_step", int'(gen_busy), 1);
      at_pos(4, 0, 10);
      sample();
      check("idle_before_queued", int'(gen_busy), 0);

      // Run mode, every 2nd frame. A step on the wrap tick adds no extra generation.
      at_pos(5, 1, 0);
      run = 1'b1;
      sb_push(EvStart, 6, 4, 0, 1'b0);
      sb_push(EvSwap, 7, 0, 0, 1'b1);
      sb_push(EvStart, 8, 4, 0, 1'b0);
      sb_push(EvSwap, 9, 0, 0, 1'b0);
      at_pos(6, 4, 0);
      pulse_step();

      at_pos(9, 1, 0);
      run = 1'b0;
      pulse_step();
      sb_push(EvStart, 9, 4, 0, 1'b0);
      sb_push(EvSwap, 10, 0, 0, 1'b1);

      // Reset in the middle of a generation abandons it.
      at_pos(10, 1, 0);
      eng_delay = 30000;
      pulse_step();
      sb_push(EvStart, 10, 4, 0, 1'b0);
      at_pos(10, 5, 100);
      sample();
      check("pre_reset_grant", int'(upd_grant), 1);
      check("pre_reset_buf", int'(buf_sel), 1);
      check("pre_reset_busy", int'(gen_busy), 1);
      check("pre_reset_vsync", int'(vsync), 0);
      at_pos(10, 5, 200);
      rst_n = 1'b0;
      #1;
      check_reset_values("async_reset");
      at_pos(10, 6, 0);
      rst_n = 1'b1;
      at_pos(11, 5, 0);
      sample();
      check("post_reset_busy", int'(gen_busy), 0);
      check("post_reset_buf", int'(buf_sel), 0);
      check("post_reset_grant", int'(upd_grant), 0);
      check("sb_leftover", sbq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
